exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
Exception/interrupt sequencer that sits between the MEM stage and the CP0 register file. It samples exception flags and hardware interrupts against the instruction in MEM, selects one exception by fixed priority, and holds the pipeline until outstanding data-bus traffic drains. It then issues a one-cycle CP0 update and a flush with a PC redirect, either to the exception vector or to EPC for ERET.

Parameters:
EXC_VECTOR, 32'hBFC00380, exception entry PC
INT_SYNC_STAGES, 2, synchroniser depth for hw_int (minimum 2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_valid  in  1  MEM stage holds a live instruction
mem_pc  in  32  PC of the MEM instruction
mem_indelayslot  in  1  MEM instruction is in a delay slot
mem_badvaddr  in  32  faulting data address (MEM)
exc_adel_if  in  1  fetch address error (badvaddr = mem_pc)
exc_ri  in  1  reserved instruction
exc_ov  in  1  arithmetic overflow
exc_sys  in  1  syscall
exc_bp  in  1  break
exc_adel_mem  in  1  load address error
exc_ades_mem  in  1  store address error
is_eret  in  1  MEM instruction is ERET
hw_int  in  6  asynchronous hardware interrupt lines
mem_busy  in  1  data-bus transaction outstanding
cp0_status  in  32  CP0 Status
cp0_cause  in  32  CP0 Cause
cp0_epc  in  32  CP0 EPC
cp0_en  out  1  one-cycle CP0 exception-write strobe
cp0_exctype  out  5  exception code to CP0
cp0_pc  out  32  PC to CP0
cp0_indelayslot  out  1  delay-slot flag to CP0
cp0_badvaddr  out  32  bad address to CP0
hw_int_sync  out  6  synchronised hw_int (feeds Cause[15:10])
stall_req  out  1  freeze IF..MEM
flush  out  1  kill IF..MEM
redirect_valid  out  1  fetch-PC override
redirect_pc  out  32  new fetch PC

Behaviour:
- Reset: state IDLE; all outputs 0; synchroniser and capture registers 0. A reset asserted mid-sequence aborts it, and no cp0_en is issued.
- Codes: INT 5'h00, ADEL 5'h04, ADES 5'h05, SYS 5'h08, BP 5'h09, RI 5'h0a, OV 5'h0c, ERET 5'h0e.
- Interrupt request: int_req = Status[0] & ~Status[1] & |({Status[15:10]&hw_int_sync, Status[9:8]&Cause[9:8]}).
- Priority, highest first: INT, ADEL_IF, RI, OV, SYS, BP, ADEL_MEM, ADES_MEM, ERET.
- A candidate exists only when mem_valid=1 and the state is IDLE.
- Badvaddr capture:
  - ADEL_IF captures mem_pc.
  - ADEL_MEM and ADES_MEM capture mem_badvaddr.
  - All other codes capture 0.
- IDLE:
  - On a candidate, latch code, pc, indelayslot and badvaddr.
  - stall_req=1 combinationally in the same cycle.
  - Next state is WAIT if mem_busy=1, else COMMIT.
- WAIT:
  - stall_req=1.
  - Latched values are held; inputs are ignored.
  - Move to COMMIT in the cycle after mem_busy is sampled 0.
- COMMIT (exactly one cycle):
  - cp0_en=1, flush=1, redirect_valid=1, stall_req=0.
  - cp0_* outputs carry the latched values.
  - redirect_pc = cp0_epc (value sampled this cycle) if the code is ERET, else EXC_VECTOR.
  - Next state is IDLE.
  - A MEM candidate present in this cycle is ignored, because the flush kills it.
- cp0_exctype, cp0_pc, cp0_indelayslot and cp0_badvaddr read 0 whenever cp0_en=0.
- Latency: from candidate detection to cp0_en is 1 cycle with no bus traffic, otherwise 1 + the number of busy cycles.
- Back-to-back: the earliest next cp0_en is 2 cycles after the previous one, because the pipeline refills after the flush.

Optional Feature:
EXC_TIMER_INT_EN
- Defined:
  - Adds inputs cp0_count[31:0], cp0_compare[31:0] and compare_wr (1 bit).
  - A sticky timer_pending flag sets on the cycle cp0_count==cp0_compare and clears on compare_wr=1; clear wins over a simultaneous set.
  - timer_pending is ORed into bit 5 of hw_int_sync after synchronisation.
  - timer_pending resets to 0.
- Undefined: these ports and the flag do not exist, and hw_int_sync[5] comes from hw_int[5] only.

Test Plan:
- Overflow, no bus traffic: mem_valid=1, exc_ov=1, mem_pc=32'h80001000, mem_busy=0 → stall_req=1 in the same cycle; next cycle cp0_en=1, cp0_exctype=5'h0c, cp0_pc=32'h80001000, redirect_pc=32'hBFC00380, flush=1.
- Store fault while bus busy: exc_ades_mem=1, mem_badvaddr=32'h00000003, mem_busy=1 for 3 cycles → stall_req held 4 cycles; then cp0_en=1 with exctype 5'h05 and badvaddr 32'h00000003.
- Priority: exc_ri=1 and exc_sys=1 together → exctype 5'h0a. Separately, with int_req=1 on the same instruction → exctype 5'h00.
- ERET: is_eret=1, cp0_epc=32'hBFC00100 → cp0_exctype=5'h0e, redirect_pc=32'hBFC00100.
- Interrupt masking and sync: Status=32'h00000401, hw_int=6'b000001 → exception taken on a valid instruction no earlier than 2 cycles after hw_int rises. With Status[1]=1 → no exception.
- Reset during WAIT: rst=1 → next cycle state IDLE, all outputs 0, and no cp0_en ever issued for the aborted event.

Source files
------------

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - MEM-stage exception/interrupt sequencer feeding CP0 with flush and PC redirect.
// Optional EXC_TIMER_INT_EN adds a sticky count/compare timer interrupt on hw_int_sync[5].
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
  parameter int          INT_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_indelayslot,
  input  logic [31:0] mem_badvaddr,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_adel_mem,
  input  logic        exc_ades_mem,
  input  logic        is_eret,
  input  logic [5:0]  hw_int,
  input  logic        mem_busy,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
`ifdef EXC_TIMER_INT_EN
  input  logic [31:0] cp0_count,
  input  logic [31:0] cp0_compare,
  input  logic        compare_wr,
`endif
  output logic        cp0_en,
  output logic [4:0]  cp0_exctype,
  output logic [31:0] cp0_pc,
  output logic        cp0_indelayslot,
  output logic [31:0] cp0_badvaddr,
  output logic [5:0]  hw_int_sync,
  output logic        stall_req,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;
  localparam logic [4:0] CODE_ERET = 5'h0e;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;
  state_t state, state_nxt;

  logic [5:0]  sync_q [INT_SYNC_STAGES];
  logic [4:0]  code_q, code_sel;
  logic [31:0] pc_q, badvaddr_q, badvaddr_sel;
  logic        ds_q;
  logic        int_req, exc_any, candidate;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < INT_SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < INT_SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef EXC_TIMER_INT_EN
  logic timer_pending;
  // Software clearing via compare_wr must win over a coincident match.
  always_ff @(posedge clk) begin
    if (rst)                           timer_pending <= 1'b0;
    else if (compare_wr)               timer_pending <= 1'b0;
    else if (cp0_count == cp0_compare) timer_pending <= 1'b1;
  end
  assign hw_int_sync = sync_q[INT_SYNC_STAGES-1] | {timer_pending, 5'b0};
`else
  assign hw_int_sync = sync_q[INT_SYNC_STAGES-1];
`endif

  assign int_req = cp0_status[0] & ~cp0_status[1] &
                   (|{cp0_status[15:10] & hw_int_sync, cp0_status[9:8] & cp0_cause[9:8]});
  assign exc_any = int_req | exc_adel_if | exc_ri | exc_ov | exc_sys | exc_bp |
                   exc_adel_mem | exc_ades_mem | is_eret;
  assign candidate = ~rst & mem_valid & (state == IDLE) & exc_any;

  always_comb begin
    code_sel     = CODE_ERET;
    badvaddr_sel = '0;
    if (int_req)           code_sel = CODE_INT;
    else if (exc_adel_if) begin
      code_sel     = CODE_ADEL;
      badvaddr_sel = mem_pc;
    end
    else if (exc_ri)       code_sel = CODE_RI;
    else if (exc_ov)       code_sel = CODE_OV;
    else if (exc_sys)      code_sel = CODE_SYS;
    else if (exc_bp)       code_sel = CODE_BP;
    else if (exc_adel_mem) begin
      code_sel     = CODE_ADEL;
      badvaddr_sel = mem_badvaddr;
    end
    else if (exc_ades_mem) begin
      code_sel     = CODE_ADES;
      badvaddr_sel = mem_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code_q     <= '0;
      pc_q       <= '0;
      ds_q       <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      state <= state_nxt;
      if (candidate) begin
        code_q     <= code_sel;
        pc_q       <= mem_pc;
        ds_q       <= mem_indelayslot;
        badvaddr_q <= badvaddr_sel;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    stall_req       = 1'b0;
    cp0_en          = 1'b0;
    cp0_exctype     = '0;
    cp0_pc          = '0;
    cp0_indelayslot = 1'b0;
    cp0_badvaddr    = '0;
    flush           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    case (state)
      IDLE: begin
        if (candidate) begin
          stall_req = 1'b1;
          state_nxt = mem_busy ? WAIT : COMMIT;
        end
      end
      WAIT: begin
        stall_req = 1'b1;
        if (!mem_busy) state_nxt = COMMIT;
      end
      COMMIT: begin
        cp0_en          = 1'b1;
        cp0_exctype     = code_q;
        cp0_pc          = pc_q;
        cp0_indelayslot = ds_q;
        cp0_badvaddr    = badvaddr_q;
        flush           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_pc     = (code_q == CODE_ERET) ? cp0_epc : EXC_VECTOR;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, cp0_status[31:16], cp0_status[7:2], cp0_cause[31:10], cp0_cause[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_indelayslot;
  logic [31:0] mem_pc, mem_badvaddr;
  logic        exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_mem, exc_ades_mem, is_eret;
  logic [5:0]  hw_int;
  logic        mem_busy;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        cp0_en, cp0_indelayslot, stall_req, flush, redirect_valid;
  logic [4:0]  cp0_exctype;
  logic [31:0] cp0_pc, cp0_badvaddr, redirect_pc;
  logic [5:0]  hw_int_sync;
`ifdef EXC_TIMER_INT_EN
  logic [31:0] cp0_count = 32'd0;
  logic [31:0] cp0_compare = 32'd1;
  logic        compare_wr = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_indelayslot(mem_indelayslot),
    .mem_badvaddr(mem_badvaddr),
    .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_ov(exc_ov), .exc_sys(exc_sys),
    .exc_bp(exc_bp), .exc_adel_mem(exc_adel_mem), .exc_ades_mem(exc_ades_mem),
    .is_eret(is_eret), .hw_int(hw_int), .mem_busy(mem_busy),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
`ifdef EXC_TIMER_INT_EN
    .cp0_count(cp0_count), .cp0_compare(cp0_compare), .compare_wr(compare_wr),
`endif
    .cp0_en(cp0_en), .cp0_exctype(cp0_exctype), .cp0_pc(cp0_pc),
    .cp0_indelayslot(cp0_indelayslot), .cp0_badvaddr(cp0_badvaddr),
    .hw_int_sync(hw_int_sync), .stall_req(stall_req), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_exc();
    mem_valid = 0; mem_indelayslot = 0; mem_pc = '0; mem_badvaddr = '0;
    exc_adel_if = 0; exc_ri = 0; exc_ov = 0; exc_sys = 0; exc_bp = 0;
    exc_adel_mem = 0; exc_ades_mem = 0; is_eret = 0; mem_busy = 0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1; clear_exc(); hw_int = '0;
    cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    step(); step();
    check("rst_cp0_en", {31'b0, cp0_en}, 0);
    check("rst_stall", {31'b0, stall_req}, 0);
    check("rst_flush", {31'b0, flush}, 0);
    check("rst_redirect", {31'b0, redirect_valid}, 0);
    check("rst_sync", {26'b0, hw_int_sync}, 0);
    rst = 0;

    // Overflow, bus idle
    step();
    mem_valid = 1; exc_ov = 1; mem_pc = 32'h80001000; mem_indelayslot = 1; #1;
    check("ov_stall", {31'b0, stall_req}, 1);
    check("ov_en_early", {31'b0, cp0_en}, 0);
    step(); clear_exc(); #1;
    check("ov_en", {31'b0, cp0_en}, 1);
    check("ov_code", {27'b0, cp0_exctype}, 32'h0c);
    check("ov_pc", cp0_pc, 32'h80001000);
    check("ov_ds", {31'b0, cp0_indelayslot}, 1);
    check("ov_bad", cp0_badvaddr, 0);
    check("ov_redir", redirect_pc, 32'hBFC00380);
    check("ov_rvalid", {31'b0, redirect_valid}, 1);
    check("ov_flush", {31'b0, flush}, 1);
    check("ov_stall_commit", {31'b0, stall_req}, 0);
    step();
    check("ov_en_after", {31'b0, cp0_en}, 0);
    check("ov_code_after", {27'b0, cp0_exctype}, 0);
    check("ov_pc_after", cp0_pc, 0);

    // Store fault while the bus stays busy for 3 cycles
    mem_valid = 1; exc_ades_mem = 1; mem_badvaddr = 32'h00000003; mem_pc = 32'h80002000; mem_busy = 1; #1;
    check("ades_stall0", {31'b0, stall_req}, 1);
    for (int c = 1; c < 4; c++) begin
      step();
      clear_exc(); mem_busy = (c < 3); mem_badvaddr = 32'hDEADBEEF; #1;
      check("ades_stall", {31'b0, stall_req}, 1);
      check("ades_en_wait", {31'b0, cp0_en}, 0);
    end
    step(); mem_badvaddr = '0; #1;
    check("ades_en", {31'b0, cp0_en}, 1);
    check("ades_code", {27'b0, cp0_exctype}, 32'h05);
    check("ades_bad", cp0_badvaddr, 32'h00000003);
    check("ades_pc", cp0_pc, 32'h80002000);
    step();

    // RI beats SYS
    mem_valid = 1; exc_ri = 1; exc_sys = 1; mem_pc = 32'h80003000;
    step(); clear_exc(); #1;
    check("ri_code", {27'b0, cp0_exctype}, 32'h0a);
    check("ri_en", {31'b0, cp0_en}, 1);
    step();

    // Software interrupt beats RI
    cp0_status = 32'h00000101; cp0_cause = 32'h00000100;
    mem_valid = 1; exc_ri = 1; mem_pc = 32'h80004000;
    step(); clear_exc(); cp0_cause = '0; #1;
    check("int_code", {27'b0, cp0_exctype}, 32'h00);
    check("int_en", {31'b0, cp0_en}, 1);
    check("int_pc", cp0_pc, 32'h80004000);
    cp0_status = '0;
    step();

    // ERET redirects to EPC
    mem_valid = 1; is_eret = 1; cp0_epc = 32'hBFC00100;
    step(); clear_exc(); #1;
    check("eret_code", {27'b0, cp0_exctype}, 32'h0e);
    check("eret_redir", redirect_pc, 32'hBFC00100);
    step();

    // Hardware interrupt through the synchroniser
    cp0_status = 32'h00000401; mem_valid = 1; hw_int = 6'b000001; #1;
    check("hw_stall_t0", {31'b0, stall_req}, 0);
    step();
    check("hw_stall_t1", {31'b0, stall_req}, 0);
    step();
    check("hw_sync", {26'b0, hw_int_sync}, 1);
    check("hw_stall_t2", {31'b0, stall_req}, 1);
    step(); mem_valid = 0; #1;
    check("hw_en", {31'b0, cp0_en}, 1);
    check("hw_code", {27'b0, cp0_exctype}, 32'h00);
    step();
    cp0_status = 32'h00000403; mem_valid = 1; #1;
    for (int c = 0; c < 3; c++) begin
      check("exl_stall", {31'b0, stall_req}, 0);
      check("exl_en", {31'b0, cp0_en}, 0);
      step();
    end
    hw_int = '0; mem_valid = 0; cp0_status = '0;
    step();

    // Reset while waiting on the bus aborts the event
    mem_valid = 1; exc_adel_mem = 1; mem_badvaddr = 32'h00000001; mem_busy = 1;
    step(); clear_exc(); mem_busy = 1; #1;
    check("abort_wait_stall", {31'b0, stall_req}, 1);
    rst = 1;
    step(); mem_busy = 0; #1;
    check("abort_stall", {31'b0, stall_req}, 0);
    check("abort_en", {31'b0, cp0_en}, 0);
    check("abort_flush", {31'b0, flush}, 0);
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("abort_no_en", {31'b0, cp0_en}, 0);
      check("abort_no_stall", {31'b0, stall_req}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
